// File: rtl/dsi_payload_loader.sv
// dsi_payload_loader
//   Feeds the DSI TX payload FIFO for one transfer at a time. The order is a
//   leading command byte (the sender discards it), then N payload bytes from a
//   valid/ready source, then the CRC-16 of the payload, low byte first. After
//   that it requests the sender with write_cmd_o and waits for the finish_i
//   handshake to complete.
//
// Ports
//   byte_clock_o   in   byte clock from the frame sender (rising edge)
//   reset_i        in   asynchronous, active-high reset
//   start_i        in   transfer request, sampled only when idle
//   cmd_code_i     in   sender ROM start address; also the leading FIFO byte
//   payload_len_i  in   payload byte count N, sampled with start_i
//   src_data_i     in   payload byte
//   src_valid_i    in   payload byte valid
//   src_ready_o    out  payload byte accepted on src_valid_i && src_ready_o
//   fifo_wdata_o   out  registered FIFO write data
//   fifo_wr_en_o   out  registered FIFO write strobe
//   fifo_afull_i   in   FIFO has at most one free entry
//   command_o      out  command for the sender
//   write_cmd_o    out  command request to the sender
//   finish_i       in   sender idle/finished flag
//   busy_o         out  high whenever not idle
//   error_o        out  one-cycle pulse when N exceeds MAX_PAYLOAD
//   crc_o          out  CRC of the last completed payload
module dsi_payload_loader #(
  parameter int unsigned MAX_PAYLOAD = 508,
  parameter logic [15:0] CRC_INIT    = 16'hFFFF
) (
  input  logic        byte_clock_o,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  cmd_code_i,
  input  logic [8:0]  payload_len_i,
  input  logic [7:0]  src_data_i,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  output logic [7:0]  fifo_wdata_o,
  output logic        fifo_wr_en_o,
  input  logic        fifo_afull_i,
  output logic [7:0]  command_o,
  output logic        write_cmd_o,
  input  logic        finish_i,
  output logic        busy_o,
  output logic        error_o,
  output logic [15:0] crc_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, PAYLOAD, CRC_L, CRC_H, ISSUE, WAIT_DONE
  } state_t;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [8:0]  len_q, len_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic [7:0]  command_q, command_d;
  logic [7:0]  fifo_wdata_q, fifo_wdata_d;
  logic        fifo_wr_en_q, fifo_wr_en_d;
  logic        write_cmd_q, write_cmd_d;
  logic        error_q, error_d;
  logic        src_ready;

  // Reflected CRC-16 (poly 0x8408), one whole byte per cycle, LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    crc_d        = crc_q;
    crc_out_d    = crc_out_q;
    command_d    = command_q;
    fifo_wdata_d = fifo_wdata_q;
    fifo_wr_en_d = 1'b0;
    write_cmd_d  = 1'b0;
    error_d      = 1'b0;
    src_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if ({1'b0, payload_len_i} > MAX_LEN) begin
            error_d = 1'b1;
          end else begin
            command_d = cmd_code_i;
            len_d     = payload_len_i;
            crc_d     = CRC_INIT;
            state_d   = CMD;
          end
        end
      end
      CMD: begin
        if (!fifo_afull_i) begin
          fifo_wr_en_d = 1'b1;
          fifo_wdata_d = command_q;
          state_d      = (len_q == '0) ? CRC_L : PAYLOAD;
        end
      end
      PAYLOAD: begin
        src_ready = !fifo_afull_i;
        if (src_valid_i && !fifo_afull_i) begin
          fifo_wr_en_d = 1'b1;
          fifo_wdata_d = src_data_i;
          crc_d        = crc_byte(crc_q, src_data_i);
          len_d        = len_q - 9'd1;
          if (len_q == 9'd1) state_d = CRC_L;
        end
      end
      CRC_L: begin
        if (!fifo_afull_i) begin
          fifo_wr_en_d = 1'b1;
          fifo_wdata_d = crc_q[7:0];
          state_d      = CRC_H;
        end
      end
      CRC_H: begin
        if (!fifo_afull_i) begin
          fifo_wr_en_d = 1'b1;
          fifo_wdata_d = crc_q[15:8];
          crc_out_d    = crc_q;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // The request is raised on the first ISSUE edge; only a low finish_i
        // seen while the request is already visible releases it, so the
        // sender always gets at least one cycle of write_cmd_o.
        if (write_cmd_q && !finish_i) begin
          state_d = WAIT_DONE;
        end else begin
          write_cmd_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (finish_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clock_o or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      crc_q        <= CRC_INIT;
      crc_out_q    <= '1;
      command_q    <= '0;
      fifo_wdata_q <= '0;
      fifo_wr_en_q <= 1'b0;
      write_cmd_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      crc_q        <= crc_d;
      crc_out_q    <= crc_out_d;
      command_q    <= command_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      write_cmd_q  <= write_cmd_d;
      error_q      <= error_d;
    end
  end

  assign src_ready_o  = src_ready;
  assign fifo_wdata_o = fifo_wdata_q;
  assign fifo_wr_en_o = fifo_wr_en_q;
  assign command_o    = command_q;
  assign write_cmd_o  = write_cmd_q;
  assign busy_o       = (state_q != IDLE);
  assign error_o      = error_q;
  assign crc_o        = crc_out_q;

endmodule

// File: tb/tb_dsi_payload_loader.sv
module tb_dsi_payload_loader;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  cmd_code_i;
  logic [8:0]  payload_len_i;
  logic [7:0]  src_data_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic [7:0]  fifo_wdata_o;
  logic        fifo_wr_en_o;
  logic        fifo_afull_i;
  logic [7:0]  command_o;
  logic        write_cmd_o;
  logic        finish_i;
  logic        busy_o;
  logic        error_o;
  logic [15:0] crc_o;

  dsi_payload_loader #(.MAX_PAYLOAD(508), .CRC_INIT(16'hFFFF)) dut (
    .byte_clock_o (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .cmd_code_i   (cmd_code_i),
    .payload_len_i(payload_len_i),
    .src_data_i   (src_data_i),
    .src_valid_i  (src_valid_i),
    .src_ready_o  (src_ready_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_afull_i (fifo_afull_i),
    .command_o    (command_o),
    .write_cmd_o  (write_cmd_o),
    .finish_i     (finish_i),
    .busy_o       (busy_o),
    .error_o      (error_o),
    .crc_o        (crc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  logic afull_s = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pay[512];

  typedef struct {
    logic [7:0]        cmd;
    int                len;
    logic [15:0][7:0]  d;
    bit                gaps;
    bit                stall;
    logic [15:0]       crc_exp;
    int                hold;
    bit                poke;
  } vec_t;

  vec_t vt[5];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    afull_s <= fifo_afull_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Bit-serial reference CRC over pay[0..len-1].
  function automatic logic [15:0] crc_model(input int len);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // FIFO scoreboard: every strobe pops one expected byte.
  always @(negedge clk) begin
    if (fifo_wr_en_o) begin
      wr_count++;
      chk("write_while_afull", {31'b0, afull_s}, 32'd0);
      if (exp_q.size() == 0) fail_now("unexpected_fifo_write");
      else chk("fifo_byte", {24'b0, fifo_wdata_o}, {24'b0, exp_q.pop_front()});
    end
  end

  // Call at a negedge with the DUT idle; returns at a negedge.
  task automatic xfer(input logic [7:0] cmd, input int len, input bit gaps, input bit stall,
                      input int abort_at, input int lat_exp, input logic [15:0] crc_exp,
                      input int hold, input bit poke);
    int s, n;
    bit acc;
    wr_count = 0;
    start_i = 1'b1; cmd_code_i = cmd; payload_len_i = 9'(len);
    exp_q.push_back(cmd);
    if (len == 0) begin exp_q.push_back(crc_exp[7:0]); exp_q.push_back(crc_exp[15:8]); end
    @(negedge clk);
    start_i = 1'b0;
    s = cyc;
    chk("busy_after_start", {31'b0, busy_o}, 32'd1);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) return;
      if (gaps && (i % 2 == 1)) begin src_valid_i = 1'b0; repeat (2) @(negedge clk); end
      src_valid_i = 1'b1; src_data_i = pay[i];
      if (stall && i == 2) begin
        fifo_afull_i = 1'b1;
        repeat (5) @(negedge clk);
        fifo_afull_i = 1'b0;
      end
      acc = 1'b0; n = 0;
      while (!acc) begin
        #4;
        acc = src_ready_o;
        @(posedge clk);
        if (acc) begin
          exp_q.push_back(pay[i]);
          if (i == len - 1) begin exp_q.push_back(crc_exp[7:0]); exp_q.push_back(crc_exp[15:8]); end
        end
        @(negedge clk);
        if (acc) src_valid_i = 1'b0;
        n++;
        if (!acc && n > 100) begin fail_now("src_accept_timeout"); src_valid_i = 1'b0; return; end
      end
    end
    n = 0;
    while (!write_cmd_o && n < 100) begin @(negedge clk); n++; end
    chk("write_cmd_rise", {31'b0, write_cmd_o}, 32'd1);
    if (lat_exp >= 0) chk("write_cmd_latency", cyc - s, lat_exp);
    chk("command_o", {24'b0, command_o}, {24'b0, cmd});
    chk("crc_o", {16'b0, crc_o}, {16'b0, crc_exp});
    chk("write_count", wr_count, len + 3);
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (hold) begin
      @(negedge clk);
      chk("write_cmd_held", {31'b0, write_cmd_o}, 32'd1);
    end
    finish_i = 1'b0;
    @(negedge clk);
    chk("write_cmd_fall", {31'b0, write_cmd_o}, 32'd0);
    chk("busy_wait_done", {31'b0, busy_o}, 32'd1);
    if (poke) begin
      start_i = 1'b1; payload_len_i = 9'd3; cmd_code_i = 8'hEE;
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_start_ignored", {31'b0, busy_o}, 32'd1);
      chk("command_unchanged", {24'b0, command_o}, {24'b0, cmd});
    end
    finish_i = 1'b1;
    @(negedge clk);
    chk("busy_done", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < 512; i++) pay[i] = 8'h00;
    for (int i = 0; i < 16; i++) pay[i] = vt[k].d[i];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_src_ready"}, {31'b0, src_ready_o}, 32'd0);
    chk({tag, "_wr_en"}, {31'b0, fifo_wr_en_o}, 32'd0);
    chk({tag, "_write_cmd"}, {31'b0, write_cmd_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_error"}, {31'b0, error_o}, 32'd0);
    chk({tag, "_wdata"}, {24'b0, fifo_wdata_o}, 32'd0);
    chk({tag, "_command"}, {24'b0, command_o}, 32'd0);
    chk({tag, "_crc_o"}, {16'b0, crc_o}, 32'h0000FFFF);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; cmd_code_i = '0; payload_len_i = '0;
    src_data_i = '0; src_valid_i = 1'b0; fifo_afull_i = 1'b0; finish_i = 1'b1;

    // Vector table
    vt[0].cmd = 8'h20; vt[0].len = 9;  vt[0].d = '0;
    for (int i = 0; i < 9; i++) vt[0].d[i] = 8'h31 + 8'(i);
    vt[0].gaps = 0; vt[0].stall = 0; vt[0].crc_exp = 16'h6F91; vt[0].hold = 1; vt[0].poke = 0;
    vt[1].cmd = 8'h40; vt[1].len = 0;  vt[1].d = '0;
    vt[1].gaps = 0; vt[1].stall = 0; vt[1].crc_exp = 16'hFFFF; vt[1].hold = 10; vt[1].poke = 1;
    vt[2].cmd = 8'h5A; vt[2].len = 4;  vt[2].d = '0;
    vt[2].d[0] = 8'hAA; vt[2].d[1] = 8'h55; vt[2].d[2] = 8'h00; vt[2].d[3] = 8'hFF;
    vt[2].gaps = 1; vt[2].stall = 1; vt[2].hold = 0; vt[2].poke = 0;
    vt[3].cmd = 8'h7E; vt[3].len = 1;  vt[3].d = '0; vt[3].d[0] = 8'hC3;
    vt[3].gaps = 0; vt[3].stall = 0; vt[3].hold = 2; vt[3].poke = 0;
    vt[4].cmd = 8'h33; vt[4].len = 16; vt[4].d = '0;
    for (int i = 0; i < 16; i++) vt[4].d[i] = 8'($urandom_range(0, 255));
    vt[4].gaps = 0; vt[4].stall = 0; vt[4].hold = 0; vt[4].poke = 1;
    for (int k = 2; k < 5; k++) begin load_vec(k); vt[k].crc_exp = crc_model(vt[k].len); end

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      load_vec(k);
      xfer(vt[k].cmd, vt[k].len, vt[k].gaps, vt[k].stall, -1,
           (vt[k].gaps || vt[k].stall) ? -1 : vt[k].len + 4,
           vt[k].crc_exp, vt[k].hold, vt[k].poke);
      @(negedge clk);
    end

    // Oversize length rejected, then the largest legal length accepted.
    wr_count = 0;
    start_i = 1'b1; payload_len_i = 9'd509; cmd_code_i = 8'h77;
    @(negedge clk);
    start_i = 1'b0;
    chk("error_pulse", {31'b0, error_o}, 32'd1);
    chk("error_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    chk("error_one_cycle", {31'b0, error_o}, 32'd0);
    chk("error_no_write", wr_count, 0);
    for (int i = 0; i < 508; i++) pay[i] = 8'($urandom_range(0, 255));
    xfer(8'h09, 508, 0, 0, -1, 512, crc_model(508), 0, 0);
    @(negedge clk);

    // Reset in the middle of a payload, then a clean transfer.
    load_vec(0);
    xfer(8'h20, 9, 0, 0, 3, -1, 16'h6F91, 0, 0);
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    src_valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    xfer(8'h20, 9, 0, 0, -1, 13, 16'h6F91, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
